// File: rtl/dump_frame_receiver.sv
// Decoder for the 6-byte serial dump frame.
// It rebuilds each voltage/current/checksum record from the received byte
// stream, drops malformed or stalled frames, and keeps saturating
// frame and error counters.
module dump_frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk100,
    input  logic             rst_p,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
    input  logic             clear_stats,
    output logic             rec_valid,
    output logic [11:0]      rec_data_v,
    output logic [11:0]      rec_data_i,
    output logic [6:0]       rec_checksum,
    output logic             rec_cks_ok,
    output logic             fmt_err,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] error_count
);

    localparam int unsigned      GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       HDR      = 8'h0A;

    typedef enum logic [2:0] {
        HUNT,
        GOT_B0,
        GOT_B1,
        GOT_B2,
        GOT_B3,
        GOT_B4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_next;
    logic [3:0]       v_hi;
    logic [7:0]       v_lo;
    logic [3:0]       i_hi;
    logic [7:0]       i_lo;
    logic             ld_v_hi;
    logic             ld_v_lo;
    logic             ld_i_hi;
    logic             ld_i_lo;
    logic             ld_rec;
    logic             fmt_evt;
    logic             to_evt;
    logic [6:0]       cks_calc;
    logic             err_inc;

    // Only the low 7 bits of the 10-bit sum matter, so the sum is formed
    // directly at 7 bits; the discarded upper bits never reach the result.
    assign cks_calc = {v_hi[2:0], v_lo[7:4]} + {v_lo[2:0], i_hi} + i_lo[6:0];

    assign busy = (state != HUNT);

    // State and inter-byte gap timer registers
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            state <= HUNT;
            gap   <= '0;
        end else begin
            state <= state_next;
            gap   <= gap_next;
        end
    end

    // Next-state decode, field latch strobes and error events
    always_comb begin
        state_next = state;
        ld_v_hi    = 1'b0;
        ld_v_lo    = 1'b0;
        ld_i_hi    = 1'b0;
        ld_i_lo    = 1'b0;
        ld_rec     = 1'b0;
        fmt_evt    = 1'b0;
        to_evt     = 1'b0;
        if (rx_dv) begin
            case (state)
                HUNT: begin
                    if (rx_byte == HDR) state_next = GOT_B0;
                end
                GOT_B0: begin
                    if (rx_byte[7:4] != 4'h0) begin
                        fmt_evt    = 1'b1;
                        state_next = HUNT;
                    end else begin
                        ld_v_hi    = 1'b1;
                        state_next = GOT_B1;
                    end
                end
                GOT_B1: begin
                    ld_v_lo    = 1'b1;
                    state_next = GOT_B2;
                end
                GOT_B2: begin
                    if (rx_byte[7:4] != 4'h0) begin
                        fmt_evt    = 1'b1;
                        state_next = HUNT;
                    end else begin
                        ld_i_hi    = 1'b1;
                        state_next = GOT_B3;
                    end
                end
                GOT_B3: begin
                    ld_i_lo    = 1'b1;
                    state_next = GOT_B4;
                end
                GOT_B4: begin
                    if (rx_byte[7]) fmt_evt = 1'b1;
                    else            ld_rec  = 1'b1;
                    state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end else if (state != HUNT && gap == GAP_LAST) begin
            to_evt     = 1'b1;
            state_next = HUNT;
        end
        gap_next = (rx_dv || state_next == HUNT) ? '0 : gap + GAP_W'(1);
    end

    // Partial-field capture and record output registers
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            v_hi         <= '0;
            v_lo         <= '0;
            i_hi         <= '0;
            i_lo         <= '0;
            rec_valid    <= 1'b0;
            rec_data_v   <= '0;
            rec_data_i   <= '0;
            rec_checksum <= '0;
            rec_cks_ok   <= 1'b0;
            fmt_err      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (ld_v_hi) v_hi <= rx_byte[3:0];
            if (ld_v_lo) v_lo <= rx_byte;
            if (ld_i_hi) i_hi <= rx_byte[3:0];
            if (ld_i_lo) i_lo <= rx_byte;
            rec_valid   <= ld_rec;
            fmt_err     <= fmt_evt;
            timeout_err <= to_evt;
            if (ld_rec) begin
                rec_data_v   <= {v_hi, v_lo};
                rec_data_i   <= {i_hi, i_lo};
                rec_checksum <= rx_byte[6:0];
                rec_cks_ok   <= (rx_byte[6:0] == cks_calc);
            end
        end
    end

    assign err_inc = (rec_valid && !rec_cks_ok) || fmt_err || timeout_err;

    // Saturating statistics counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            frame_count <= '0;
            error_count <= '0;
        end else if (clear_stats) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            if (rec_valid && frame_count != '1) frame_count <= frame_count + CNT_W'(1);
            if (err_inc && error_count != '1)   error_count <= error_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dump_frame_receiver.sv
// Scoreboard bench for dump_frame_receiver: expected records are queued when a
// frame is driven and compared when rec_valid appears. A second instance with
// narrow counters covers saturation.
module tb_dump_frame_receiver;

    localparam int unsigned T_MAIN   = 40;
    localparam int unsigned CNT_MAIN = 16;
    localparam int unsigned T_SAT    = 100000;
    localparam int unsigned CNT_SAT  = 2;

    logic        clk100 = 1'b0;
    logic        rst_p;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        clear_stats;

    logic                rec_valid;
    logic [11:0]         rec_data_v;
    logic [11:0]         rec_data_i;
    logic [6:0]          rec_checksum;
    logic                rec_cks_ok;
    logic                fmt_err;
    logic                timeout_err;
    logic                busy;
    logic [CNT_MAIN-1:0] frame_count;
    logic [CNT_MAIN-1:0] error_count;

    logic                sat_rec_valid;
    logic [11:0]         sat_rec_data_v;
    logic [11:0]         sat_rec_data_i;
    logic [6:0]          sat_rec_checksum;
    logic                sat_rec_cks_ok;
    logic                sat_fmt_err;
    logic                sat_timeout_err;
    logic                sat_busy;
    logic [CNT_SAT-1:0]  sat_frame_count;
    logic [CNT_SAT-1:0]  sat_error_count;

    dump_frame_receiver #(.TIMEOUT_CYCLES(T_MAIN), .CNT_W(CNT_MAIN)) dut (
        .clk100(clk100), .rst_p(rst_p), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .clear_stats(clear_stats), .rec_valid(rec_valid), .rec_data_v(rec_data_v),
        .rec_data_i(rec_data_i), .rec_checksum(rec_checksum), .rec_cks_ok(rec_cks_ok),
        .fmt_err(fmt_err), .timeout_err(timeout_err), .busy(busy),
        .frame_count(frame_count), .error_count(error_count)
    );

    dump_frame_receiver #(.TIMEOUT_CYCLES(T_SAT), .CNT_W(CNT_SAT)) dut_sat (
        .clk100(clk100), .rst_p(rst_p), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .clear_stats(clear_stats), .rec_valid(sat_rec_valid), .rec_data_v(sat_rec_data_v),
        .rec_data_i(sat_rec_data_i), .rec_checksum(sat_rec_checksum), .rec_cks_ok(sat_rec_cks_ok),
        .fmt_err(sat_fmt_err), .timeout_err(sat_timeout_err), .busy(sat_busy),
        .frame_count(sat_frame_count), .error_count(sat_error_count)
    );

    always #5 clk100 = ~clk100;

    typedef struct packed {
        logic [11:0] v;
        logic [11:0] i;
        logic [6:0]  cks;
        logic        ok;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_exp;
    rec_t mon_got;
    int   n_pass     = 0;
    int   n_total    = 0;
    int   exp_frames = 0;
    int   exp_errors = 0;

    function automatic logic [6:0] calc_cks(input logic [11:0] v, input logic [11:0] i);
        logic [9:0] s;
        s = 10'(v[11:4]) + 10'({v[3:0], i[11:8]}) + 10'(i[7:0]);
        return s[6:0];
    endfunction

    // Record monitor: every rec_valid must match the oldest queued expectation
    always @(negedge clk100) begin
        if (!rst_p && rec_valid === 1'b1) begin
            n_total++;
            mon_got = {rec_data_v, rec_data_i, rec_checksum, rec_cks_ok};
            if (exp_q.size() == 0) begin
                $display("FAIL rec_unexpected: got v=%h i=%h cks=%h ok=%b, required no record",
                         rec_data_v, rec_data_i, rec_checksum, rec_cks_ok);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL rec_fields: got v=%h i=%h cks=%h ok=%b, required v=%h i=%h cks=%h ok=%b",
                             rec_data_v, rec_data_i, rec_checksum, rec_cks_ok,
                             mon_exp.v, mon_exp.i, mon_exp.cks, mon_exp.ok);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk100);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk100);
        #1;
        rx_dv   = 1'b0;
        rx_byte = '0;
    endtask

    task automatic send_frame(input logic [11:0] v, input logic [11:0] i, input logic [6:0] cks,
                              input int gap_before, input int gap_len);
        logic [7:0] bytes [6];
        rec_t r;
        bytes[0] = 8'h0A;
        bytes[1] = {4'h0, v[11:8]};
        bytes[2] = v[7:0];
        bytes[3] = {4'h0, i[11:8]};
        bytes[4] = i[7:0];
        bytes[5] = {1'b0, cks};
        r.v   = v;
        r.i   = i;
        r.cks = cks;
        r.ok  = (cks == calc_cks(v, i));
        exp_q.push_back(r);
        for (int k = 0; k < 6; k++) begin
            if (k == gap_before) idle(gap_len);
            send_byte(bytes[k]);
        end
        n_total++;
        if (rec_valid !== 1'b1) $display("FAIL rec_latency: rec_valid=%b, required 1", rec_valid);
        else n_pass++;
        exp_frames++;
        if (!r.ok) exp_errors++;
    endtask

    task automatic test_reset();
        rst_p = 1'b1; rx_dv = 1'b0; rx_byte = '0; clear_stats = 1'b0;
        idle(2);
        n_total++;
        if ({rec_valid, rec_data_v, rec_data_i, rec_checksum, rec_cks_ok, fmt_err,
             timeout_err, busy, frame_count, error_count} !== '0)
            $display("FAIL reset_outputs: got v=%h i=%h cks=%h busy=%b fc=%0d ec=%0d, required all 0",
                     rec_data_v, rec_data_i, rec_checksum, busy, frame_count, error_count);
        else n_pass++;
        rst_p = 1'b0;
        idle(2);
    endtask

    task automatic test_checksum();
        send_frame(12'hABC, 12'h567, 7'h3C, -1, 0);
        idle(1);
        n_total++;
        if ({rec_cks_ok, frame_count, error_count} !== {1'b0, 16'd1, 16'd1})
            $display("FAIL cks_bad: ok=%b fc=%0d ec=%0d, required ok=0 fc=1 ec=1", rec_cks_ok, frame_count, error_count);
        else n_pass++;
        send_frame(12'hABC, 12'h567, 7'h57, -1, 0);
        idle(3);
        n_total++;
        if ({rec_valid, rec_cks_ok, rec_data_v, frame_count, error_count} !== {1'b0, 1'b1, 12'hABC, 16'd2, 16'd1})
            $display("FAIL cks_good_hold: valid=%b ok=%b v=%h fc=%0d ec=%0d, required 0 1 abc 2 1",
                     rec_valid, rec_cks_ok, rec_data_v, frame_count, error_count);
        else n_pass++;
    endtask

    task automatic test_noise();
        send_byte(8'h55);
        send_byte(8'hFF);
        send_byte(8'h13);
        idle(2);
        n_total++;
        if ({busy, error_count} !== {1'b0, 16'(exp_errors)})
            $display("FAIL noise_silent: busy=%b ec=%0d, required busy=0 ec=%0d", busy, error_count, exp_errors);
        else n_pass++;
        send_frame(12'h000, 12'h000, 7'h00, -1, 0);
        idle(1);
        n_total++;
        if ({frame_count, error_count} !== {16'(exp_frames), 16'(exp_errors)})
            $display("FAIL noise_counts: fc=%0d ec=%0d, required fc=%0d ec=%0d", frame_count, error_count, exp_frames, exp_errors);
        else n_pass++;
    endtask

    task automatic test_fmt();
        send_byte(8'h0A);
        send_byte(8'h1F);
        exp_errors++;
        n_total++;
        if ({fmt_err, busy} !== 2'b10)
            $display("FAIL fmt_b1_pulse: fmt_err=%b busy=%b, required 1 0", fmt_err, busy);
        else n_pass++;
        idle(1);
        n_total++;
        if ({fmt_err, rec_data_v, error_count} !== {1'b0, 12'h000, 16'(exp_errors)})
            $display("FAIL fmt_b1_after: fmt_err=%b v=%h ec=%0d, required 0 000 %0d", fmt_err, rec_data_v, error_count, exp_errors);
        else n_pass++;
        send_frame(12'h123, 12'h456, calc_cks(12'h123, 12'h456), -1, 0);
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h02); send_byte(8'hF3);
        exp_errors++;
        n_total++;
        if ({fmt_err, busy} !== 2'b10)
            $display("FAIL fmt_b3_pulse: fmt_err=%b busy=%b, required 1 0", fmt_err, busy);
        else n_pass++;
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte({1'b1, calc_cks(12'h102, 12'h304)});
        exp_errors++;
        n_total++;
        if ({fmt_err, rec_valid, busy} !== 3'b100)
            $display("FAIL fmt_b5_pulse: fmt_err=%b rec_valid=%b busy=%b, required 1 0 0", fmt_err, rec_valid, busy);
        else n_pass++;
        idle(1);
        n_total++;
        if ({rec_data_v, rec_data_i, frame_count, error_count} !== {12'h123, 12'h456, 16'(exp_frames), 16'(exp_errors)})
            $display("FAIL fmt_hold: v=%h i=%h fc=%0d ec=%0d, required 123 456 %0d %0d",
                     rec_data_v, rec_data_i, frame_count, error_count, exp_frames, exp_errors);
        else n_pass++;
    endtask

    task automatic test_timeout();
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h02);
        idle(T_MAIN - 1);
        n_total++;
        if ({timeout_err, busy} !== 2'b01)
            $display("FAIL timeout_early: timeout_err=%b busy=%b, required 0 1", timeout_err, busy);
        else n_pass++;
        idle(1);
        exp_errors++;
        n_total++;
        if ({timeout_err, busy} !== 2'b10)
            $display("FAIL timeout_pulse: timeout_err=%b busy=%b, required 1 0", timeout_err, busy);
        else n_pass++;
        idle(T_MAIN + 5);
        n_total++;
        if ({timeout_err, error_count} !== {1'b0, 16'(exp_errors)})
            $display("FAIL timeout_single: timeout_err=%b ec=%0d, required 0 %0d", timeout_err, error_count, exp_errors);
        else n_pass++;
        // 4th byte lands on the cycle the gap timer reaches its limit
        send_frame(12'h102, 12'h304, calc_cks(12'h102, 12'h304), 3, T_MAIN - 1);
        idle(1);
        n_total++;
        if ({frame_count, error_count} !== {16'(exp_frames), 16'(exp_errors)})
            $display("FAIL timeout_race: fc=%0d ec=%0d, required fc=%0d ec=%0d", frame_count, error_count, exp_frames, exp_errors);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h02);
        rst_p = 1'b1;
        idle(1);
        n_total++;
        if ({rec_valid, rec_data_v, rec_data_i, rec_checksum, rec_cks_ok, fmt_err,
             timeout_err, busy, frame_count, error_count} !== '0)
            $display("FAIL midreset_outputs: got v=%h i=%h cks=%h busy=%b fc=%0d ec=%0d, required all 0",
                     rec_data_v, rec_data_i, rec_checksum, busy, frame_count, error_count);
        else n_pass++;
        rst_p = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        idle(1);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        idle(1);
        n_total++;
        if ({rec_valid, busy, rec_data_v, frame_count, error_count} !== '0)
            $display("FAIL midreset_nohdr: valid=%b busy=%b v=%h fc=%0d ec=%0d, required all 0",
                     rec_valid, busy, rec_data_v, frame_count, error_count);
        else n_pass++;
        send_frame(12'hFFF, 12'hFFF, calc_cks(12'hFFF, 12'hFFF), -1, 0);
        idle(1);
        n_total++;
        if ({frame_count, error_count} !== {16'(exp_frames), 16'(exp_errors)})
            $display("FAIL midreset_counts: fc=%0d ec=%0d, required fc=%0d ec=%0d", frame_count, error_count, exp_frames, exp_errors);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_frame(12'h5A5, 12'h0F0, calc_cks(12'h5A5, 12'h0F0), -1, 0);
        send_frame(12'h800, 12'h001, 7'h7F, -1, 0);
        send_frame(12'h0A0, 12'h0A0, calc_cks(12'h0A0, 12'h0A0), -1, 0);
        idle(1);
        n_total++;
        if ({frame_count, error_count} !== {16'(exp_frames), 16'(exp_errors)})
            $display("FAIL b2b_counts: fc=%0d ec=%0d, required fc=%0d ec=%0d", frame_count, error_count, exp_frames, exp_errors);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [11:0] v;
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        n_total++;
        if ({frame_count, error_count, sat_frame_count, sat_error_count} !== '0)
            $display("FAIL clear_idle: fc=%0d ec=%0d sat_fc=%0d sat_ec=%0d, required all 0",
                     frame_count, error_count, sat_frame_count, sat_error_count);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            v = 12'(k * 12'h111);
            send_frame(v, 12'h222, calc_cks(v, 12'h222) ^ 7'h01, -1, 0);
        end
        idle(1);
        n_total++;
        if ({frame_count, error_count, sat_frame_count, sat_error_count} !== {16'd5, 16'd5, 2'd3, 2'd3})
            $display("FAIL sat_counts: fc=%0d ec=%0d sat_fc=%0d sat_ec=%0d, required 5 5 3 3",
                     frame_count, error_count, sat_frame_count, sat_error_count);
        else n_pass++;
        send_frame(12'h321, 12'h654, calc_cks(12'h321, 12'h654), -1, 0);
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        n_total++;
        if ({frame_count, error_count, sat_frame_count, sat_error_count} !== '0)
            $display("FAIL clear_wins: fc=%0d ec=%0d sat_fc=%0d sat_ec=%0d, required all 0",
                     frame_count, error_count, sat_frame_count, sat_error_count);
        else n_pass++;
        idle(2);
        n_total++;
        if ({frame_count, error_count, sat_rec_cks_ok} !== {16'd0, 16'd0, 1'b1})
            $display("FAIL clear_stays: fc=%0d ec=%0d sat_ok=%b, required 0 0 1", frame_count, error_count, sat_rec_cks_ok);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_checksum();
        test_noise();
        test_fmt();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_saturation();
        idle(2);
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL records_outstanding: %0d expected records never appeared, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dump_frame_receiver.md
Name: dump_frame_receiver

Overview:
Host-side decoder for the 6-byte serial dump frame emitted by the sampling/dump controller. Sits behind a UART receiver in loopback/self-test builds and in the bench-side capture FPGA. Consumes the received byte stream and reconstructs each stored meter record (voltage, current, checksum). Verifies frame format and checksum, and keeps frame and error statistics.

Parameters:
TIMEOUT_CYCLES, 100000, inter-byte gap in clk100 cycles (1 ms) after which a partial frame is abandoned
CNT_W, 16, width of the saturating statistics counters

Ports:
clk100  in  1  system clock, 100 MHz
rst_p  in  1  reset, asynchronous, active-high
rx_dv  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received byte
clear_stats  in  1  synchronous clear of frame_count/error_count
rec_valid  out  1  one-cycle pulse: record fields updated
rec_data_v  out  12  reconstructed voltage sample
rec_data_i  out  12  reconstructed current sample
rec_checksum  out  7  checksum as received
rec_cks_ok  out  1  received checksum equals recomputed checksum; valid with rec_valid, held until next record
fmt_err  out  1  one-cycle pulse: format violation, frame dropped
timeout_err  out  1  one-cycle pulse: partial frame abandoned on gap
busy  out  1  high while a frame is in progress (state != HUNT)
frame_count  out  CNT_W  records delivered, saturating
error_count  out  CNT_W  checksum mismatches + fmt_err + timeout_err, saturating

Behaviour:
- Reset (rst_p): state HUNT, all outputs 0, gap counter 0, byte registers 0.
- Frame layout: B0=0x0A header; B1={4'h0,V[11:8]}; B2=V[7:0]; B3={4'h0,I[11:8]}; B4=I[7:0]; B5={1'b0,CKS[6:0]}.
- States: HUNT, GOT_B0, GOT_B1, GOT_B2, GOT_B3, GOT_B4. Transitions occur only on a cycle with rx_dv=1.
- HUNT: byte==0x0A -> GOT_B0. Any other byte is discarded silently, with no error.
- GOT_B0: B1[7:4]!=0 -> fmt_err, HUNT. Otherwise latch V[11:8] -> GOT_B1.
- GOT_B1: latch V[7:0] -> GOT_B2.
- GOT_B2: B3[7:4]!=0 -> fmt_err, HUNT. Otherwise latch I[11:8] -> GOT_B3.
- GOT_B3: latch I[7:0] -> GOT_B4.
- GOT_B4: B5[7]!=0 -> fmt_err, HUNT.
  - Otherwise update rec_data_v, rec_data_i, rec_checksum and rec_cks_ok; pulse rec_valid; go to HUNT.
  - Latency: rec_valid is high exactly one cycle after the rx_dv cycle carrying B5.
- The byte that causes fmt_err is consumed. It is never re-examined as a header.
- Checksum recompute: (V[11:4] + {V[3:0],I[11:8]} + I[7:0]) mod 128, i.e. low 7 bits of a 10-bit sum. Compare with B5[6:0].
- Counters:
  - frame_count increments on every rec_valid, including checksum failures.
  - error_count increments on rec_valid with rec_cks_ok=0, on fmt_err, and on timeout_err.
  - Each event adds exactly 1. Events are mutually exclusive per cycle.
  - Both counters saturate at all-ones and never wrap.
  - clear_stats zeroes both counters. If clear_stats coincides with an increment, the counter is 0 after that cycle (clear wins).
- Gap timer:
  - Counts clk100 cycles while state != HUNT; reset to 0 on each rx_dv and on entry to HUNT.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_dv that cycle: pulse timeout_err, go to HUNT.
  - If rx_dv and the timeout coincide in the same cycle, the byte wins and no timeout occurs.
- In HUNT the timer is held at 0, so an idle line never produces errors.
- rec_* fields hold their last values between records. fmt_err and timeout_err never change rec_*.
- busy = (state != HUNT), registered with the state.
- rx_dv asserted on consecutive cycles is legal. Each assertion is one byte, with no dropped bytes.

Test Plan:
- Feed bytes 0A 0A BC 05 67 3C (V=0xABC, I=0x567; sum 0xAB+0xC5+0x67=0x1D7, low 7 bits 0x57) -> rec_valid one cycle after the 6th rx_dv; rec_data_v=0xABC, rec_data_i=0x567, rec_checksum=0x3C, rec_cks_ok=0, frame_count=1, error_count=1. Repeat with last byte 0x57 -> rec_cks_ok=1, frame_count=2, error_count=1.
- Noise 55 FF 13, then frame 0A 00 00 00 00 00 -> no errors from the noise; rec_valid with V=0, I=0, rec_cks_ok=1.
- 0A 1F (bad B1 nibble), then a valid frame -> fmt_err pulse after the 2nd byte, error_count=1, busy drops; the following frame decodes correctly.
- 0A 01 02, then silence for TIMEOUT_CYCLES -> single timeout_err pulse, busy=0, error_count=1. Repeat with the 4th byte arriving exactly on the timeout cycle -> no timeout; the frame continues.
- Assert rst_p mid-frame after 0A 01 02, then send 03 04 05 -> no rec_valid and all outputs 0 (no header seen); the next full frame decodes.
- Set TIMEOUT_CYCLES large and CNT_W=2, send 5 bad-checksum frames -> error_count saturates at 3. Then clear_stats coinciding with a rec_valid -> both counters read 0.
